// File: rtl/pipe_ctrl_if.sv
// Signal bundle between the Y86-64 pipeline datapath and its control unit.
// Pure wiring; no storage, so it adds no latency.
// No backpressure; every field is a level that is sampled each cycle.
//
// master : datapath side (drives stage icodes/status, receives strobes/counters)
// slave  : pipe_ctrl side
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    // datapath -> control
    logic             clr_cnt;
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;
    // control -> datapath
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             set_cc;
    logic             halted;
    logic [2:0]       stat_out;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output clr_cnt, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, stat_out, cycle_cnt, stall_cnt, mispred_cnt
    );

    modport slave (
        input  clr_cnt, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               set_cc, halted, stat_out, cycle_cnt, stall_cnt, mispred_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble strobes, post-reset flush, halt on W exception, perf counters.
// Strobes are combinational (0 cycles); halted/stat_out follow a W exception by 1 cycle.
// No backpressure of its own; it is the source of pipeline stalls.
//
// Ports: clk, rst (async active-high) plus pipe_ctrl_if.slave p carrying stage
// icodes/status in and stall/bubble/set_cc/halted/stat_out/counters out.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  p
);
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0]       FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic lu, rt, mp, exc_m, exc_w;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;

    // Hazard terms.
    always_comb begin
        lu    = ((p.E_icode == I_MRMOVQ) || (p.E_icode == I_POPQ)) &&
                (p.E_dstM != R_NONE) &&
                ((p.E_dstM == p.d_srcA) || (p.E_dstM == p.d_srcB));
        rt    = (p.D_icode == I_RET) || (p.E_icode == I_RET) || (p.M_icode == I_RET);
        mp    = (p.E_icode == I_JXX) && !p.e_Cnd;
        exc_m = (p.m_stat == S_HLT) || (p.m_stat == S_ADR) || (p.m_stat == S_INS);
        exc_w = (p.W_stat == S_HLT) || (p.W_stat == S_ADR) || (p.W_stat == S_INS);
    end

    // Run-state machine and strobe generation.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stat_d      = stat_q;
        f_stall     = 1'b0;
        d_stall     = 1'b0;
        d_bubble    = 1'b0;
        e_bubble    = 1'b0;
        m_bubble    = 1'b0;
        w_stall     = 1'b0;
        set_cc      = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                // Registers have no reset: push NOPs through D/E/M until garbage is gone.
                f_stall     = 1'b1;
                d_bubble    = 1'b1;
                e_bubble    = 1'b1;
                m_bubble    = 1'b1;
                flush_cnt_d = flush_cnt_q + 4'd1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            end
            ST_RUN: begin
                f_stall  = lu | rt;
                d_stall  = lu;
                // Load/use holds D, so a ret bubble must not overwrite the held instruction.
                d_bubble = mp | (rt & !lu);
                e_bubble = mp | lu;
                m_bubble = exc_m | exc_w;
                w_stall  = exc_w;
                // An excepting instruction ahead of E must not see CC side effects.
                set_cc   = (p.E_icode == I_OPQ) & !exc_m & !exc_w;
                if (exc_w) begin
                    state_d = ST_HALTED;
                    stat_d  = p.W_stat;
                end
            end
            ST_HALTED: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                w_stall  = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
            end
            default: begin
                state_d     = ST_FLUSH;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Saturating counters; clear wins over increment and works in every state.
    always_comb begin
        cycle_d   = cycle_q;
        stall_d   = stall_q;
        mispred_d = mispred_q;
        if (p.clr_cnt) begin
            cycle_d   = '0;
            stall_d   = '0;
            mispred_d = '0;
        end else if (state_q == ST_RUN) begin
            if (cycle_q != CNT_MAX)
                cycle_d = cycle_q + 1'b1;
            if (f_stall && (stall_q != CNT_MAX))
                stall_d = stall_q + 1'b1;
            if (mp && (mispred_q != CNT_MAX))
                mispred_d = mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= '0;
            stat_q      <= S_AOK;
            cycle_q     <= '0;
            stall_q     <= '0;
            mispred_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stat_q      <= stat_d;
            cycle_q     <= cycle_d;
            stall_q     <= stall_d;
            mispred_q   <= mispred_d;
        end
    end

    assign p.F_stall     = f_stall;
    assign p.D_stall     = d_stall;
    assign p.D_bubble    = d_bubble;
    assign p.E_bubble    = e_bubble;
    assign p.M_bubble    = m_bubble;
    assign p.W_stall     = w_stall;
    assign p.set_cc      = set_cc;
    assign p.halted      = (state_q == ST_HALTED);
    assign p.stat_out    = stat_q;
    assign p.cycle_cnt   = cycle_q;
    assign p.stall_cnt   = stall_q;
    assign p.mispred_cnt = mispred_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic against a reference model.
// Outputs are compared at the falling edge; the model advances at each rising edge.
// DUT has no backpressure; reset is injected randomly to replay the flush.
module tb_pipe_ctrl;
    localparam int FLUSH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CW)) pif ();

    pipe_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .p   (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: mode 0 = flushing, 1 = running, 2 = halted.
    int m_mode;
    int m_flush_edges;
    int m_stat;
    int m_cyc, m_stl, m_mis;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic bit h_lu();
        return ((pif.E_icode == 4'h5) || (pif.E_icode == 4'hB)) && (pif.E_dstM != 4'hF) &&
               ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
    endfunction

    function automatic bit h_rt();
        return (pif.D_icode == 4'h9) || (pif.E_icode == 4'h9) || (pif.M_icode == 4'h9);
    endfunction

    function automatic bit h_mp();
        return (pif.E_icode == 4'h7) && !pif.e_Cnd;
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
    function automatic logic [7:0] exp_outs();
        bit lu, rt, mp, em, ew;
        if (m_mode == 0) return 8'b1011_1000;
        if (m_mode == 2) return 8'b1101_1101;
        lu = h_lu(); rt = h_rt(); mp = h_mp();
        em = is_exc(pif.m_stat); ew = is_exc(pif.W_stat);
        return {lu | rt, lu, mp | (rt & !lu), mp | lu, em | ew, ew,
                (pif.E_icode == 4'h6) & !em & !ew, 1'b0};
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_flush_edges = 0; m_stat = 1;
        m_cyc = 0; m_stl = 0; m_mis = 0;
    endtask

    // Apply one rising edge to the model using the inputs present before the edge.
    task automatic model_edge();
        logic [7:0] o;
        o = exp_outs();
        if (pif.clr_cnt) begin
            m_cyc = 0; m_stl = 0; m_mis = 0;
        end else if (m_mode == 1) begin
            m_cyc = sat(m_cyc + 1);
            if (o[7]) m_stl = sat(m_stl + 1);
            if (h_mp()) m_mis = sat(m_mis + 1);
        end
        if (m_mode == 0) begin
            m_flush_edges++;
            if (m_flush_edges == FLUSH) m_mode = 1;
        end else if (m_mode == 1 && is_exc(pif.W_stat)) begin
            m_mode = 2;
            m_stat = int'(pif.W_stat);
        end
    endtask

    task automatic check_all();
        chk_eq("strobes", {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble,
                           pif.M_bubble, pif.W_stall, pif.set_cc, pif.halted}, exp_outs());
        chk_eq("stat_out", pif.stat_out, m_stat);
        chk_eq("cycle_cnt", pif.cycle_cnt, m_cyc);
        chk_eq("stall_cnt", pif.stall_cnt, m_stl);
        chk_eq("mispred_cnt", pif.mispred_cnt, m_mis);
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge,
    // return 1 time unit later so new inputs are driven away from the edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic set_in(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] ei, input logic [3:0] edm, input logic cnd,
                          input logic [3:0] mi, input logic [2:0] ms, input logic [2:0] ws);
        pif.D_icode = di; pif.d_srcA = sa; pif.d_srcB = sb;
        pif.E_icode = ei; pif.E_dstM = edm; pif.e_Cnd = cnd;
        pif.M_icode = mi; pif.m_stat = ms; pif.W_stat = ws;
    endtask

    task automatic idle();
        set_in(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
    endtask

    task automatic clear_cnt();
        pif.clr_cnt = 1'b1;
        cycle();
        pif.clr_cnt = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        pif.clr_cnt = 1'b0;
        idle();
        rst = 1'b1;
        model_reset();

        // Reset held for 3 cycles, then the flush.
        repeat (3) cycle();
        rst = 1'b0;
        repeat (FLUSH) cycle();
        chk_eq("run_after_flush_cyc", pif.cycle_cnt, 0);
        cycle();
        chk_eq("first_run_edge_cyc", pif.cycle_cnt, 1);

        // Load/use on srcA.
        clear_cnt();
        set_in(4'h6, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 3'd1);
        repeat (3) cycle();
        chk_eq("lu_stall_cnt", pif.stall_cnt, 3);

        // Mispredict, then a taken jump.
        clear_cnt();
        set_in(4'h2, 4'h1, 4'h2, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        cycle();
        chk_eq("mp_cnt_one", pif.mispred_cnt, 1);
        pif.e_Cnd = 1'b1;
        repeat (2) cycle();

        // ret together with load/use, then ret alone.
        set_in(4'h9, 4'hF, 4'h4, 4'hB, 4'h4, 1'b0, 4'h1, 3'd1, 3'd1);
        repeat (2) cycle();
        set_in(4'h9, 4'hF, 4'h4, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        repeat (2) cycle();
        // ret with mispredict.
        set_in(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1);
        cycle();

        // Memory exception suppresses set_cc, then W exception halts.
        set_in(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd3, 3'd1);
        cycle();
        set_in(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd1, 3'd3);
        cycle();
        idle();
        repeat (3) cycle();
        chk_eq("halted_after_w_exc", pif.halted, 1);
        chk_eq("halted_stat", pif.stat_out, 3);

        // Asynchronous reset from HALTED.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_eq("rst_async_halted", pif.halted, 0);
        chk_eq("rst_async_cyc", pif.cycle_cnt, 0);
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        repeat (FLUSH) cycle();

        // Saturation and clear.
        repeat (20) cycle();
        chk_eq("cyc_saturated", pif.cycle_cnt, CMAX);
        clear_cnt();
        chk_eq("cyc_cleared", pif.cycle_cnt, 1'b0);
        cycle();

        // Random traffic with occasional exceptions, clears and resets.
        for (int i = 0; i < 600; i++) begin
            pif.D_icode = 4'($urandom_range(0, 11));
            pif.E_icode = 4'($urandom_range(0, 11));
            pif.M_icode = 4'($urandom_range(0, 11));
            pif.d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            pif.d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            pif.E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
            pif.e_Cnd   = 1'($urandom_range(0, 1));
            pif.m_stat  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd1;
            pif.W_stat  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            pif.clr_cnt = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle();
        end
        rst = 1'b0;
        pif.clr_cnt = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
